// File: rtl/sitosoe_param_serializer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : sitosoe_pkg                                                   |
// | Brief  : Shared sizing helpers for the vector serializer family and    |
// |          an elaboration-time legality check for the lane count.        |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
package sitosoe_pkg;

  // Number of beats needed to replay one vector.
  function automatic int series_count(input int num_elem, input int lanes);
    return num_elem / lanes;
  endfunction

  // Beat-index width; a single-beat series still needs one bit.
  function automatic int sw_width(input int series);
    return (series <= 1) ? 1 : $clog2(series);
  endfunction

endpackage

// Rejects lane counts that do not tile the vector exactly.
`ifndef SITOSOE_CHECK_DIVIDES
`define SITOSOE_CHECK_DIVIDES(N, L) \
  if (((L) < 1) || ((L) > (N)) || (((N) % (L)) != 0)) begin : g_lanes_check \
    $error("sitosoe: LANES must divide NUM_ELEM and lie in 1..NUM_ELEM"); \
  end
`endif
`default_nettype wire

// File: rtl/sitosoe_param_serializer_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : sitosoe_param_serializer_if                                   |
// | Brief  : Vector-in / beat-out bundle for the serializer.               |
// |          master : drives enable, inReady, A; observes all outputs      |
// |          slave  : the serializer side                                  |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
interface sitosoe_param_serializer_if
  import sitosoe_pkg::*;
#(
  parameter int IN_WIDTH = 10,
  parameter int NUM_ELEM = 10,
  parameter int LANES    = 5
);
  localparam int SERIES = series_count(NUM_ELEM, LANES);
  localparam int SW     = sw_width(SERIES);

  logic                         enable;
  logic                         inReady;
  logic [NUM_ELEM*IN_WIDTH-1:0] A;
  logic                         newInSeriesStart;
  logic [LANES*IN_WIDTH-1:0]    O;
  logic                         OutReady;
  logic [SW-1:0]                outSeries;
  logic                         lastSeries;
  logic                         inOverrun;

  modport master (
    output enable, inReady, A,
    input  newInSeriesStart, O, OutReady, outSeries, lastSeries, inOverrun
  );

  modport slave (
    input  enable, inReady, A,
    output newInSeriesStart, O, OutReady, outSeries, lastSeries, inOverrun
  );
endinterface
`default_nettype wire

// File: rtl/sitosoe_param_serializer_series_counter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : series_counter                                                |
// | Brief  : Beat sequencer. load restarts at beat 0, advance steps one    |
// |          beat and saturates on the final beat.                         |
// |          clk, reset (async, high) | load, advance in | count, last out|
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module series_counter
  import sitosoe_pkg::*;
#(
  parameter int SERIES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic                        advance,
  output logic [sw_width(SERIES)-1:0] count,
  output logic                        last
);
  localparam int            SW     = sw_width(SERIES);
  localparam logic [SW-1:0] c_LAST = SW'(SERIES - 1);

  logic [SW-1:0] count_q;
  logic [SW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (advance && (count_q != c_LAST)) begin
      count_d = count_q + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
  assign last  = (count_q == c_LAST);
endmodule
`default_nettype wire

// File: rtl/sitosoe_param_serializer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : sitosoe_param_serializer                                      |
// | Brief  : Captures a NUM_ELEM-element vector and replays it as          |
// |          NUM_ELEM/LANES beats of LANES elements, with zero-bubble      |
// |          back-to-back vectors, global stall and sticky overrun.        |
// |          clk, reset (async, high) | bus : slave modport               |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module sitosoe_param_serializer
  import sitosoe_pkg::*;
#(
  parameter int IN_WIDTH = 10,
  parameter int NUM_ELEM = 10,
  parameter int LANES    = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  sitosoe_param_serializer_if.slave   bus
);
  localparam int SERIES = series_count(NUM_ELEM, LANES);
  localparam int SW     = sw_width(SERIES);
  localparam int BEAT_W = LANES * IN_WIDTH;
  localparam int VEC_W  = NUM_ELEM * IN_WIDTH;
  localparam int SLOTS  = 2 ** SW;
  // Beat index whose successor is the final beat.
  localparam logic [SW-1:0] c_PEN = SW'((SERIES > 1) ? (SERIES - 2) : 0);

  `SITOSOE_CHECK_DIVIDES(NUM_ELEM, LANES)

  logic [VEC_W-1:0]  buffer_q, buffer_d;
  logic [BEAT_W-1:0] o_q, o_d;
  logic              out_ready_q, out_ready_d;
  logic              last_series_q, last_series_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  logic              new_start;
  logic              accept;
  logic              advance;
  logic              go_idle;
  logic [SW-1:0]     cnt;
  logic              cnt_last;
  logic [SW-1:0]     nxt_idx;

  // Slot table is padded to a power of two so nxt_idx never indexes
  // outside it, even in the single-beat configuration.
  logic [BEAT_W-1:0] slice [SLOTS];

  for (genvar s = 0; s < SLOTS; s++) begin : g_slice
    if (s < SERIES) begin : g_used
      assign slice[s] = buffer_q[s*BEAT_W +: BEAT_W];
    end else begin : g_pad
      assign slice[s] = '0;
    end
  end

  series_counter #(
    .SERIES (SERIES)
  ) u_series_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .advance (advance),
    .count   (cnt),
    .last    (cnt_last)
  );

  // Registers only: no path from inReady or A.
  assign new_start = !busy_q || (out_ready_q && last_series_q);
  assign accept    = bus.enable && bus.inReady && new_start;
  assign advance   = bus.enable && busy_q && !cnt_last && !accept;
  assign go_idle   = bus.enable && busy_q &&  cnt_last && !accept;
  assign nxt_idx   = cnt + SW'(1);

  always_comb begin
    buffer_d      = buffer_q;
    o_d           = o_q;
    out_ready_d   = out_ready_q;
    last_series_d = last_series_q;
    busy_d        = busy_q;
    overrun_d     = overrun_q | (bus.enable && bus.inReady && !new_start);
    if (accept) begin
      // Beat 0 comes straight from A so it is visible one edge after capture.
      buffer_d      = bus.A;
      o_d           = bus.A[BEAT_W-1:0];
      out_ready_d   = 1'b1;
      busy_d        = 1'b1;
      last_series_d = (SERIES == 1);
    end else if (advance) begin
      o_d           = slice[nxt_idx];
      last_series_d = (cnt == c_PEN);
    end else if (go_idle) begin
      // O and outSeries deliberately keep their stale values.
      busy_d        = 1'b0;
      out_ready_d   = 1'b0;
      last_series_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buffer_q      <= '0;
      o_q           <= '0;
      out_ready_q   <= 1'b0;
      last_series_q <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      buffer_q      <= buffer_d;
      o_q           <= o_d;
      out_ready_q   <= out_ready_d;
      last_series_q <= last_series_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.newInSeriesStart = new_start;
  assign bus.O                = o_q;
  assign bus.OutReady         = out_ready_q;
  assign bus.outSeries        = cnt;
  assign bus.lastSeries       = last_series_q;
  assign bus.inOverrun        = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_sitosoe_param_serializer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_sitosoe_param_serializer                                   |
// | Brief  : Directed self-checking bench for three serializer shapes:     |
// |          10/5 (two beats), 12/3 (four beats), 10/10 (pass-through).    |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module tb_sitosoe_param_serializer;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  sitosoe_param_serializer_if #(.IN_WIDTH(10), .NUM_ELEM(10), .LANES(5))  if0 ();
  sitosoe_param_serializer_if #(.IN_WIDTH(10), .NUM_ELEM(12), .LANES(3))  if1 ();
  sitosoe_param_serializer_if #(.IN_WIDTH(10), .NUM_ELEM(10), .LANES(10)) if2 ();

  sitosoe_param_serializer #(.IN_WIDTH(10), .NUM_ELEM(10), .LANES(5))
    u_dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  sitosoe_param_serializer #(.IN_WIDTH(10), .NUM_ELEM(12), .LANES(3))
    u_dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  sitosoe_param_serializer #(.IN_WIDTH(10), .NUM_ELEM(10), .LANES(10))
    u_dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs n consecutive 10-bit signed elements base, base+1, ...
  function automatic logic [127:0] mk(input int base, input int n);
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[k*10 +: 10] = 10'(base + k);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(input string tag, input logic [127:0] o, input int s,
                      input logic rdy, input logic lst);
    chk({tag, ".O"},          128'(if0.O),          o);
    chk({tag, ".outSeries"},  128'(if0.outSeries),  128'(s));
    chk({tag, ".OutReady"},   128'(if0.OutReady),   128'(rdy));
    chk({tag, ".lastSeries"}, 128'(if0.lastSeries), 128'(lst));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    if0.enable = 1'b1; if0.inReady = 1'b0; if0.A = '0;
    if1.enable = 1'b1; if1.inReady = 1'b0; if1.A = '0;
    if2.enable = 1'b1; if2.inReady = 1'b0; if2.A = '0;
    #12;
    chk0("reset", 128'(0), 0, 1'b0, 1'b0);
    chk("reset.newStart", 128'(if0.newInSeriesStart), 128'(1));
    chk("reset.overrun",  128'(if0.inOverrun),        128'(0));
    tick();
    reset = 1'b0;

    // Single vector -5..4
    if0.A = 100'(mk(-5, 10)); if0.inReady = 1'b1;
    tick();
    if0.inReady = 1'b0;
    chk0("single.b0", mk(-5, 5), 0, 1'b1, 1'b0);
    chk("single.b0.newStart", 128'(if0.newInSeriesStart), 128'(0));
    tick();
    chk0("single.b1", mk(0, 5), 1, 1'b1, 1'b1);
    tick();
    chk0("single.idle", mk(0, 5), 1, 1'b0, 1'b0);

    // Back-to-back: second vector offered on the last beat of the first
    if0.A = 100'(mk(20, 10)); if0.inReady = 1'b1;
    tick();
    if0.inReady = 1'b0;
    chk0("b2b.A0", mk(20, 5), 0, 1'b1, 1'b0);
    tick();
    chk0("b2b.A1", mk(25, 5), 1, 1'b1, 1'b1);
    chk("b2b.newStart", 128'(if0.newInSeriesStart), 128'(1));
    if0.A = 100'(mk(40, 10)); if0.inReady = 1'b1;
    tick();
    if0.inReady = 1'b0;
    chk0("b2b.B0", mk(40, 5), 0, 1'b1, 1'b0);
    chk("b2b.overrun", 128'(if0.inOverrun), 128'(0));
    tick();
    chk0("b2b.B1", mk(45, 5), 1, 1'b1, 1'b1);
    tick();
    chk("b2b.idle", 128'(if0.OutReady), 128'(0));

    // Stall for three cycles during beat 0, inReady pulsing meanwhile
    if0.A = 100'(mk(200, 10)); if0.inReady = 1'b1;
    tick();
    if0.inReady = 1'b0;
    chk0("stall.b0", mk(200, 5), 0, 1'b1, 1'b0);
    if0.enable = 1'b0; if0.inReady = 1'b1; if0.A = 100'(mk(300, 10));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk0("stall.hold", mk(200, 5), 0, 1'b1, 1'b0);
      chk("stall.overrun", 128'(if0.inOverrun), 128'(0));
    end
    if0.enable = 1'b1; if0.inReady = 1'b0;
    tick();
    chk0("stall.b1", mk(205, 5), 1, 1'b1, 1'b1);
    tick();
    chk("stall.idle", 128'(if0.OutReady), 128'(0));

    // Overrun: pulse during beat 0
    if0.A = 100'(mk(-100, 10)); if0.inReady = 1'b1;
    tick();
    chk0("ovr.b0", mk(-100, 5), 0, 1'b1, 1'b0);
    if0.A = 100'(mk(100, 10)); if0.inReady = 1'b1;
    tick();
    if0.inReady = 1'b0;
    chk("ovr.flag", 128'(if0.inOverrun), 128'(1));
    chk0("ovr.b1", mk(-95, 5), 1, 1'b1, 1'b1);
    tick();
    chk("ovr.idle", 128'(if0.OutReady), 128'(0));
    chk("ovr.sticky", 128'(if0.inOverrun), 128'(1));

    // Async reset mid beat 1 of the 12/3 instance
    if1.A = 120'(mk(-6, 12)); if1.inReady = 1'b1;
    tick();
    if1.inReady = 1'b0;
    chk("ar.b0.O", 128'(if1.O), mk(-6, 3));
    tick();
    chk("ar.b1.O", 128'(if1.O), mk(-3, 3));
    chk("ar.b1.series", 128'(if1.outSeries), 128'(1));
    #3 reset = 1'b1;
    #1;
    chk("ar.O",        128'(if1.O),                128'(0));
    chk("ar.OutReady", 128'(if1.OutReady),         128'(0));
    chk("ar.series",   128'(if1.outSeries),        128'(0));
    chk("ar.last",     128'(if1.lastSeries),       128'(0));
    chk("ar.newStart", 128'(if1.newInSeriesStart), 128'(1));
    chk("ar.overrun0", 128'(if0.inOverrun),        128'(0));
    #1 reset = 1'b0;
    if1.A = 120'(mk(50, 12)); if1.inReady = 1'b1;
    tick();
    if1.inReady = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (s > 0) tick();
      chk("ar.post.O",      128'(if1.O),          mk(50 + 3*s, 3));
      chk("ar.post.series", 128'(if1.outSeries),  128'(s));
      chk("ar.post.last",   128'(if1.lastSeries), 128'(s == 3));
    end

    // Single-beat pass-through, a new vector every cycle
    chk("pt.newStart.idle", 128'(if2.newInSeriesStart), 128'(1));
    if2.inReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if2.A = 100'(mk(k*10 - 30, 10));
      tick();
      chk("pt.O",        128'(if2.O),                mk(k*10 - 30, 10));
      chk("pt.ready",    128'(if2.OutReady),         128'(1));
      chk("pt.last",     128'(if2.lastSeries),       128'(1));
      chk("pt.newStart", 128'(if2.newInSeriesStart), 128'(1));
    end
    if2.inReady = 1'b0;
    chk("pt.overrun", 128'(if2.inOverrun), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
